// File: rtl/load_unit_rd_if.sv
// Load-unit handshake bundle: LSU request/writeback, MMU, store-offset checker and D$ read port.
// The load unit takes the slave view; the environment (LSU/MMU/D$) takes the master view.
interface load_unit_rd_if #(
  parameter int unsigned TRANS_ID_BITS = 3
);
  logic                     flush_i;
  logic                     valid_i;
  logic                     ready_o;
  logic [63:0]              vaddr_i;
  logic [1:0]               size_i;
  logic                     sign_ext_i;
  logic [TRANS_ID_BITS-1:0] trans_id_i;
  logic                     translation_req_o;
  logic [63:0]              vaddr_o;
  logic                     dtlb_hit_i;
  logic [63:0]              paddr_i;
  logic                     ex_valid_i;
  logic [11:0]              page_offset_o;
  logic                     page_offset_matches_i;
  logic                     data_req_o;
  logic [11:0]              address_index_o;
  logic                     data_gnt_i;
  logic                     tag_valid_o;
  logic [43:0]              address_tag_o;
  logic                     kill_req_o;
  logic                     data_rvalid_i;
  logic [63:0]              data_rdata_i;
  logic                     valid_o;
  logic [TRANS_ID_BITS-1:0] trans_id_o;
  logic [63:0]              result_o;
  logic                     ex_valid_o;

  modport master (
    output flush_i, valid_i, vaddr_i, size_i, sign_ext_i, trans_id_i,
           dtlb_hit_i, paddr_i, ex_valid_i, page_offset_matches_i,
           data_gnt_i, data_rvalid_i, data_rdata_i,
    input  ready_o, translation_req_o, vaddr_o, page_offset_o, data_req_o,
           address_index_o, tag_valid_o, address_tag_o, kill_req_o,
           valid_o, trans_id_o, result_o, ex_valid_o
  );

  modport slave (
    input  flush_i, valid_i, vaddr_i, size_i, sign_ext_i, trans_id_i,
           dtlb_hit_i, paddr_i, ex_valid_i, page_offset_matches_i,
           data_gnt_i, data_rvalid_i, data_rdata_i,
    output ready_o, translation_req_o, vaddr_o, page_offset_o, data_req_o,
           address_index_o, tag_valid_o, address_tag_o, kill_req_o,
           valid_o, trans_id_o, result_o, ex_valid_o
  );
endinterface

// File: rtl/load_unit_rd.sv
// Single-outstanding load unit: translate, wait out matching stores, index/tag D$ read,
// then write back the aligned and extended result.
module load_unit_rd #(
  parameter int unsigned TRANS_ID_BITS = 3
) (
  input logic           clk_i,
  input logic           rst_i,
  load_unit_rd_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    TRANSLATE,
    WAIT_PAGE_OFFSET,
    WAIT_GNT,
    SEND_TAG,
    WAIT_RVALID,
    WAIT_FLUSH
  } state_e;

  state_e                   state_q;
  state_e                   req_next;
  logic [63:0]              vaddr_q;
  logic [43:0]              tag_q;
  logic [1:0]               size_q;
  logic                     sign_q;
  logic [TRANS_ID_BITS-1:0] trans_id_q;

  logic        hit_ok;
  logic        req;
  logic        gnt_taken;
  logic        exc_wb;
  logic        data_wb;
  logic [63:0] shifted;
  logic [63:0] ext;
  logic        unused_paddr;

  assign unused_paddr = ^{bus.paddr_i[63:56], bus.paddr_i[11:0]};

  // The index request is Mealy: it goes out in the same cycle the hit / offset release is seen.
  always_comb begin
    hit_ok    = (state_q == TRANSLATE) && bus.dtlb_hit_i && !bus.ex_valid_i;
    req       = (hit_ok && !bus.page_offset_matches_i)
             || ((state_q == WAIT_PAGE_OFFSET) && !bus.page_offset_matches_i)
             || (state_q == WAIT_GNT);
    gnt_taken = req && bus.data_gnt_i;
    if (bus.data_gnt_i) req_next = bus.flush_i ? WAIT_FLUSH : SEND_TAG;
    else                req_next = bus.flush_i ? IDLE : WAIT_GNT;
    exc_wb    = (state_q == TRANSLATE) && bus.dtlb_hit_i && bus.ex_valid_i && !bus.flush_i;
    data_wb   = (state_q == WAIT_RVALID) && bus.data_rvalid_i && !bus.flush_i;
  end

  always_comb begin
    shifted = bus.data_rdata_i >> {vaddr_q[2:0], 3'b000};
    case (size_q)
      2'd0:    ext = {{56{sign_q & shifted[7]}},  shifted[7:0]};
      2'd1:    ext = {{48{sign_q & shifted[15]}}, shifted[15:0]};
      2'd2:    ext = {{32{sign_q & shifted[31]}}, shifted[31:0]};
      default: ext = shifted;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      vaddr_q    <= '0;
      tag_q      <= '0;
      size_q     <= '0;
      sign_q     <= 1'b0;
      trans_id_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.valid_i) begin
            vaddr_q    <= bus.vaddr_i;
            size_q     <= bus.size_i;
            sign_q     <= bus.sign_ext_i;
            trans_id_q <= bus.trans_id_i;
            state_q    <= TRANSLATE;
          end
        end
        TRANSLATE: begin
          if (bus.dtlb_hit_i) begin
            tag_q <= bus.paddr_i[55:12];
            if (bus.ex_valid_i)                 state_q <= IDLE;
            else if (bus.page_offset_matches_i) state_q <= bus.flush_i ? IDLE : WAIT_PAGE_OFFSET;
            else                                state_q <= req_next;
          end else if (bus.flush_i) begin
            state_q <= IDLE;
          end
        end
        WAIT_PAGE_OFFSET: begin
          if (bus.page_offset_matches_i) state_q <= bus.flush_i ? IDLE : WAIT_PAGE_OFFSET;
          else                           state_q <= req_next;
        end
        WAIT_GNT:    state_q <= req_next;
        SEND_TAG:    state_q <= bus.flush_i ? WAIT_FLUSH : WAIT_RVALID;
        WAIT_RVALID: begin
          if (bus.data_rvalid_i) state_q <= IDLE;
          else if (bus.flush_i)  state_q <= WAIT_FLUSH;
        end
        WAIT_FLUSH: begin
          if (bus.data_rvalid_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Once the D$ has granted, the request can only be abandoned through kill_req_o.
  assign bus.kill_req_o = bus.flush_i && (gnt_taken || (state_q == SEND_TAG)
                        || ((state_q == WAIT_RVALID) && !bus.data_rvalid_i));

  assign bus.ready_o           = (state_q == IDLE);
  assign bus.translation_req_o = (state_q == TRANSLATE);
  assign bus.vaddr_o           = vaddr_q;
  assign bus.page_offset_o     = vaddr_q[11:0];
  assign bus.data_req_o        = req;
  assign bus.address_index_o   = vaddr_q[11:0];
  assign bus.tag_valid_o       = (state_q == SEND_TAG);
  assign bus.address_tag_o     = tag_q;
  assign bus.valid_o           = exc_wb || data_wb;
  assign bus.ex_valid_o        = exc_wb;
  assign bus.trans_id_o        = trans_id_q;
  assign bus.result_o          = data_wb ? ext : '0;

endmodule

// File: tb/tb_load_unit_rd.sv
// Self-checking bench for load_unit_rd: directed scenarios plus randomized loads against a
// transaction-level model of the expected handshake sequence and extended result.
module tb_load_unit_rd;
  localparam int unsigned TIDW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  load_unit_rd_if #(.TRANS_ID_BITS(TIDW)) bus();
  load_unit_rd #(.TRANS_ID_BITS(TIDW)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  // Control outputs packed as {ready, treq, dreq, tag_valid, kill, valid, ex_valid}.
  function automatic logic [6:0] outs();
    return {bus.ready_o, bus.translation_req_o, bus.data_req_o, bus.tag_valid_o,
            bus.kill_req_o, bus.valid_o, bus.ex_valid_o};
  endfunction

  // Reference: byte-lane select then extension, done with plain integer arithmetic.
  function automatic logic [63:0] ref_result(input logic [63:0] d, input logic [2:0] off,
                                             input logic [1:0] sz, input logic sx);
    longint unsigned v;
    int unsigned     nb;
    v  = d >> (8 * off);
    nb = 8 << sz;
    if (nb < 64) begin
      v = v % (64'd1 << nb);
      if (sx && v >= (64'd1 << (nb - 1))) v = v - (64'd1 << nb);
    end
    return v;
  endfunction

  task automatic clear_inputs();
    bus.flush_i = 0; bus.valid_i = 0; bus.dtlb_hit_i = 0; bus.ex_valid_i = 0;
    bus.page_offset_matches_i = 0; bus.data_gnt_i = 0; bus.data_rvalid_i = 0;
    bus.vaddr_i = {$urandom, $urandom}; bus.size_i = 2'($urandom_range(0, 3));
    bus.sign_ext_i = ($urandom_range(0, 1) == 1); bus.trans_id_i = TIDW'($urandom);
    bus.paddr_i = {$urandom, $urandom}; bus.data_rdata_i = {$urandom, $urandom};
  endtask

  // In-flight cycles also wiggle valid_i, which must be ignored outside IDLE.
  task automatic busy_inputs();
    clear_inputs();
    bus.valid_i = ($urandom_range(0, 1) == 1);
  endtask

  task automatic finish_load(input string nm, input logic killed);
    int unsigned gap;
    if (killed) begin
      gap = $urandom_range(0, 2);
      for (int unsigned s = 0; s <= gap; s++) begin
        @(negedge clk); busy_inputs(); bus.data_rvalid_i = (s == gap); #1;
        checks++;
        if (outs() !== 7'b0000000) begin
          errors++; $display("FAIL %s swallow: got %b want %b", nm, outs(), 7'b0000000);
        end
      end
    end
    @(negedge clk); clear_inputs(); #1;
    checks++;
    if (outs() !== 7'b1000000) begin
      errors++; $display("FAIL %s back_idle: got %b want %b", nm, outs(), 7'b1000000);
    end
  endtask

  // One load transaction; flush_at is the cycle index (0 = acceptance) carrying flush_i, -1 for none.
  task automatic do_load(input string nm, input logic [63:0] va, input logic [63:0] pa,
                         input logic [63:0] rd, input logic [1:0] sz, input logic sx,
                         input logic [TIDW-1:0] id, input int unsigned hit_dly,
                         input int unsigned match_cyc, input int unsigned gnt_dly,
                         input int unsigned rv_dly, input logic ex, input int flush_at);
    int          cyc;
    logic [6:0]  e;
    logic        first_tr;
    logic [63:0] want;
    cyc = 0;
    @(negedge clk); clear_inputs();
    bus.valid_i = 1; bus.vaddr_i = va; bus.size_i = sz; bus.sign_ext_i = sx;
    bus.trans_id_i = id; bus.flush_i = (flush_at == 0); #1;
    checks++;
    if (outs() !== 7'b1000000) begin
      errors++; $display("FAIL %s accept: got %b want %b", nm, outs(), 7'b1000000);
    end
    for (int unsigned k = 0; k < hit_dly; k++) begin
      @(negedge clk); busy_inputs(); cyc++; bus.flush_i = (cyc == flush_at); #1;
      checks++;
      if ({outs(), bus.vaddr_o} !== {7'b0100000, va}) begin
        errors++; $display("FAIL %s tlb_miss: got %b/%h want %b/%h", nm, outs(), bus.vaddr_o, 7'b0100000, va);
      end
      if (bus.flush_i) begin finish_load(nm, 1'b0); return; end
    end
    if (ex) begin
      @(negedge clk); busy_inputs(); cyc++; bus.flush_i = (cyc == flush_at);
      bus.dtlb_hit_i = 1; bus.paddr_i = pa; bus.ex_valid_i = 1;
      bus.page_offset_matches_i = ($urandom_range(0, 1) == 1); #1;
      e = bus.flush_i ? 7'b0100000 : 7'b0100011;
      checks++;
      if (outs() !== e) begin
        errors++; $display("FAIL %s exception: got %b want %b", nm, outs(), e);
      end
      if (!bus.flush_i) begin
        checks++;
        if ({bus.trans_id_o, bus.result_o} !== {id, 64'd0}) begin
          errors++; $display("FAIL %s exc_wb: got %h/%h want %h/0", nm, bus.trans_id_o, bus.result_o, id);
        end
      end
      finish_load(nm, 1'b0); return;
    end
    for (int unsigned m = 0; m < match_cyc; m++) begin
      @(negedge clk); busy_inputs(); cyc++; bus.flush_i = (cyc == flush_at);
      bus.dtlb_hit_i = (m == 0); if (m == 0) bus.paddr_i = pa;
      bus.page_offset_matches_i = 1; #1;
      e = (m == 0) ? 7'b0100000 : 7'b0000000;
      checks++;
      if ({outs(), bus.page_offset_o} !== {e, va[11:0]}) begin
        errors++; $display("FAIL %s offset_stall: got %b/%h want %b/%h", nm, outs(), bus.page_offset_o, e, va[11:0]);
      end
      if (bus.flush_i) begin finish_load(nm, 1'b0); return; end
    end
    for (int unsigned g = 0; g <= gnt_dly; g++) begin
      @(negedge clk); busy_inputs(); cyc++; bus.flush_i = (cyc == flush_at);
      first_tr = (g == 0) && (match_cyc == 0);
      bus.dtlb_hit_i = first_tr; if (first_tr) bus.paddr_i = pa;
      bus.data_gnt_i = (g == gnt_dly); #1;
      e = {1'b0, first_tr, 1'b1, 1'b0, bus.flush_i & bus.data_gnt_i, 2'b00};
      checks++;
      if ({outs(), bus.address_index_o} !== {e, va[11:0]}) begin
        errors++; $display("FAIL %s index_req: got %b/%h want %b/%h", nm, outs(), bus.address_index_o, e, va[11:0]);
      end
      if (bus.flush_i) begin finish_load(nm, bus.data_gnt_i); return; end
    end
    @(negedge clk); busy_inputs(); cyc++; bus.flush_i = (cyc == flush_at); #1;
    e = {4'b0001, bus.flush_i, 2'b00};
    checks++;
    if ({outs(), bus.address_tag_o} !== {e, pa[55:12]}) begin
      errors++; $display("FAIL %s send_tag: got %b/%h want %b/%h", nm, outs(), bus.address_tag_o, e, pa[55:12]);
    end
    if (bus.flush_i) begin finish_load(nm, 1'b1); return; end
    want = ref_result(rd, va[2:0], sz, sx);
    for (int unsigned w = 1; w <= rv_dly; w++) begin
      @(negedge clk); busy_inputs(); cyc++; bus.flush_i = (cyc == flush_at);
      bus.data_rvalid_i = (w == rv_dly); if (w == rv_dly) bus.data_rdata_i = rd; #1;
      e = {4'b0000, bus.flush_i & !bus.data_rvalid_i, bus.data_rvalid_i & !bus.flush_i, 1'b0};
      checks++;
      if (outs() !== e) begin
        errors++; $display("FAIL %s rvalid_wait: got %b want %b", nm, outs(), e);
      end
      if (e[1]) begin
        checks++;
        if ({bus.trans_id_o, bus.result_o} !== {id, want}) begin
          errors++; $display("FAIL %s result: got %h/%h want %h/%h", nm, bus.trans_id_o, bus.result_o, id, want);
        end
      end
      if (bus.data_rvalid_i || bus.flush_i) begin
        finish_load(nm, bus.flush_i & !bus.data_rvalid_i); return;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({outs(), bus.trans_id_o, bus.result_o, bus.vaddr_o, bus.address_index_o,
         bus.page_offset_o, bus.address_tag_o} !== {7'b1000000, 199'd0}) begin
      errors++; $display("FAIL reset_state: got %b id=%h res=%h va=%h tag=%h", outs(), bus.trans_id_o,
                         bus.result_o, bus.vaddr_o, bus.address_tag_o);
    end
    rst = 0;
  endtask

  task automatic test_basic_byte();
    do_load("basic_byte", 64'h1003, 64'h8000_1003, 64'h0000_0000_8100_0000, 2'd0, 1'b1, 3'd5,
            0, 0, 0, 1, 1'b0, -1);
  endtask

  task automatic test_word_stall();
    do_load("word_stall", 64'h2004, 64'h0000_0012_3456_7004, 64'hDEAD_BEEF_0000_0000, 2'd2, 1'b0, 3'd2,
            3, 0, 2, 2, 1'b0, -1);
  endtask

  task automatic test_page_offset();
    do_load("page_offset", 64'h0000_7000_0000_3ABE, 64'h00F0_0000_0004_5ABE, 64'h1234_8765_4321_FEDC,
            2'd1, 1'b1, 3'd6, 1, 5, 0, 3, 1'b0, -1);
  endtask

  task automatic test_exception();
    do_load("exception", 64'h4000, 64'h4000, 64'h0, 2'd3, 1'b0, 3'd7, 1, 0, 0, 1, 1'b1, -1);
  endtask

  task automatic test_flush_after_grant();
    do_load("flush_wait_rvalid", 64'h5008, 64'h9000_5008, 64'h55, 2'd3, 1'b0, 3'd1, 0, 0, 0, 3, 1'b0, 3);
  endtask

  task automatic test_flush_cases();
    do_load("flush_translate", 64'h10, 64'h10, 64'h0, 2'd0, 1'b0, 3'd0, 2, 0, 0, 1, 1'b0, 1);
    do_load("flush_with_gnt",  64'h18, 64'h18, 64'h0, 2'd1, 1'b0, 3'd1, 0, 0, 0, 1, 1'b0, 1);
    do_load("flush_wait_gnt",  64'h20, 64'h20, 64'h0, 2'd2, 1'b0, 3'd2, 0, 0, 3, 1, 1'b0, 2);
    do_load("flush_send_tag",  64'h28, 64'h28, 64'h0, 2'd3, 1'b0, 3'd3, 0, 0, 0, 1, 1'b0, 2);
    do_load("flush_at_rvalid", 64'h30, 64'h30, 64'hFF, 2'd0, 1'b1, 3'd4, 0, 0, 0, 1, 1'b0, 3);
    do_load("flush_exception", 64'h38, 64'h38, 64'h0, 2'd0, 1'b0, 3'd5, 0, 0, 0, 1, 1'b1, 1);
    do_load("flush_offset",    64'h40, 64'h40, 64'h0, 2'd0, 1'b0, 3'd6, 0, 3, 0, 1, 1'b0, 2);
    do_load("flush_in_idle",   64'h4F, 64'hA04F, 64'h8000_0000_0000_0000, 2'd0, 1'b1, 3'd7,
            0, 0, 0, 2, 1'b0, 0);
  endtask

  task automatic test_reset_mid();
    @(negedge clk); clear_inputs(); bus.valid_i = 1; bus.vaddr_i = 64'h6000; bus.trans_id_i = 3'd3;
    @(negedge clk); clear_inputs(); bus.dtlb_hit_i = 1; bus.paddr_i = 64'hB000_6000;
    @(negedge clk); clear_inputs(); rst = 1; #1;
    checks++;
    if (outs() !== 7'b0010000) begin
      errors++; $display("FAIL rst_mid_pre: got %b want %b", outs(), 7'b0010000);
    end
    @(negedge clk); clear_inputs(); rst = 0; bus.data_gnt_i = 1; #1;
    checks++;
    if ({outs(), bus.trans_id_o, bus.result_o, bus.vaddr_o, bus.address_index_o,
         bus.page_offset_o, bus.address_tag_o} !== {7'b1000000, 199'd0}) begin
      errors++; $display("FAIL rst_mid_state: got %b id=%h va=%h tag=%h", outs(), bus.trans_id_o,
                         bus.vaddr_o, bus.address_tag_o);
    end
    @(negedge clk); clear_inputs(); bus.data_rvalid_i = 1; #1;
    checks++;
    if (outs() !== 7'b1000000) begin
      errors++; $display("FAIL rst_mid_late_rvalid: got %b want %b", outs(), 7'b1000000);
    end
  endtask

  task automatic test_random();
    int fl;
    for (int unsigned n = 0; n < 80; n++) begin
      fl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 12)) : -1;
      do_load("random", {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
              2'($urandom_range(0, 3)), ($urandom_range(0, 1) == 1), TIDW'($urandom),
              $urandom_range(0, 3), ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0,
              $urandom_range(0, 3), $urandom_range(1, 4), ($urandom_range(0, 7) == 0), fl);
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_basic_byte();
    test_word_stall();
    test_page_offset();
    test_exception();
    test_flush_after_grant();
    test_flush_cases();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
